// File: rtl/gat_layer_scheduler.sv
// gat_layer_scheduler: runs NUM_LAYERS GAT passes and streams each layer's features.
// Optional watchdog on the RUN wait is built when GAT_SCHED_WDT_EN is defined.
module gat_layer_scheduler #(
    parameter int          NUM_LAYERS  = 2,
    parameter int          FEAT_DEPTH  = 43328,
    parameter int          FEAT_WIDTH  = 32,
    parameter int          FEAT_ADDR_W = $clog2(FEAT_DEPTH),
    parameter int          RD_LAT      = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] WDT_CYCLES  = 32'd16777216
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              h_data_load_done_in,
    input  logic                              h_node_info_load_done_in,
    input  logic                              wgt_load_done_in,
    input  logic                              gat_ready,
    input  logic [FEAT_WIDTH-1:0]             feat_bram_dout,
    input  logic                              out_ready,
    output logic                              gat_layer,
    output logic                              h_data_bram_load_done,
    output logic                              h_node_info_bram_load_done,
    output logic                              wgt_bram_load_done,
    output logic [FEAT_ADDR_W+1:0]            feat_bram_addrb,
    output logic                              out_valid,
    output logic [FEAT_WIDTH-1:0]             out_data,
    output logic                              out_last,
    output logic [$clog2(NUM_LAYERS):0]       layer_idx,
    output logic                              reload_req,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int LW = $clog2(NUM_LAYERS) + 1;
    localparam int IW = FEAT_ADDR_W + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        READOUT,
        NEXT,
        DONE
    } state_t;

    state_t          state;
    logic            h_flag;
    logic            n_flag;
    logic            w_flag;
    logic            run_q;
    logic            rdy_q;
    logic            rdy_q2;
    logic            rdy_rise;
    logic            wdt_hit;
    logic [IW-1:0]   rd_idx;
    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT-1:0] lpipe;
    logic [FEAT_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [SW-1:0]   occupancy;
    logic            issue;
    logic            last_issue;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign h_data_bram_load_done      = run_q;
    assign h_node_info_bram_load_done = run_q;
    assign wgt_bram_load_done         = run_q;

    assign rdy_rise = rdy_q & ~rdy_q2;

    // Words still in the BRAM pipe count against FIFO space so nothing overflows.
    always_comb begin
        occupancy = SW'(fifo_count);
        for (int i = 0; i < RD_LAT; i++) begin
            occupancy = occupancy + SW'(vpipe[i]);
        end
    end

    assign issue      = (state == READOUT) &&
                        (rd_idx < IW'(FEAT_DEPTH)) &&
                        (occupancy < SW'(FIFO_DEPTH));
    assign last_issue = (rd_idx == IW'(FEAT_DEPTH - 1));
    assign push       = vpipe[RD_LAT-1];
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid & out_ready;
    assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last   = out_valid & fifo_last[rd_ptr];

`ifdef GAT_SCHED_WDT_EN
    logic [31:0] wdt_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != RUN) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end

    assign wdt_hit = (state == RUN) && (wdt_cnt == WDT_CYCLES - 32'd1);
`else
    assign wdt_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h_flag     <= 1'b0;
            n_flag     <= 1'b0;
            w_flag     <= 1'b0;
            run_q      <= 1'b0;
            rdy_q      <= 1'b0;
            rdy_q2     <= 1'b0;
            gat_layer  <= 1'b0;
            layer_idx  <= '0;
            reload_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef GAT_SCHED_WDT_EN
            err        <= 1'b0;
`endif
        end else begin
            rdy_q      <= gat_ready;
            rdy_q2     <= rdy_q;
            reload_req <= 1'b0;
            if (h_data_load_done_in)      h_flag <= 1'b1;
            if (h_node_info_load_done_in) n_flag <= 1'b1;
            if (wgt_load_done_in)         w_flag <= 1'b1;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        layer_idx <= '0;
                        gat_layer <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        h_flag    <= 1'b0;
                        n_flag    <= 1'b0;
                        w_flag    <= 1'b0;
`ifdef GAT_SCHED_WDT_EN
                        err       <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (h_flag && n_flag && w_flag) begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (wdt_hit) begin
                        state <= IDLE;
                        run_q <= 1'b0;
                        busy  <= 1'b0;
`ifdef GAT_SCHED_WDT_EN
                        err   <= 1'b1;
`endif
                    end else if (rdy_rise) begin
                        state <= READOUT;
                        run_q <= 1'b0;
                    end
                end
                READOUT: begin
                    if (pop && out_last) begin
                        if (layer_idx == LW'(NUM_LAYERS - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= NEXT;
                            layer_idx  <= layer_idx + LW'(1);
                            reload_req <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    state     <= LOAD;
                    gat_layer <= layer_idx[0];
                    h_flag    <= 1'b0;
                    n_flag    <= 1'b0;
                    w_flag    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    run_q <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx          <= '0;
            feat_bram_addrb <= '0;
            vpipe           <= '0;
            lpipe           <= '0;
        end else begin
            if (state != READOUT) begin
                rd_idx <= '0;
            end else if (issue) begin
                rd_idx <= rd_idx + IW'(1);
            end
            if (issue) begin
                feat_bram_addrb <= {rd_idx[FEAT_ADDR_W-1:0], 2'b00};
            end
            vpipe[0] <= issue;
            lpipe[0] <= issue & last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= feat_bram_dout;
            fifo_last[wr_ptr] <= lpipe[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// tb_gat_layer_scheduler: directed checks of the layer scheduler with FEAT_DEPTH=8.
// Define GAT_SCHED_WDT_EN to also cover the watchdog path.
module tb_gat_layer_scheduler;

    localparam int FD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hl;
    logic        nl;
    logic        wl;
    logic        gat_ready;
    logic [31:0] feat_bram_dout = '0;
    logic        out_ready;
    logic        gat_layer;
    logic        h_data_bram_load_done;
    logic        h_node_info_bram_load_done;
    logic        wgt_bram_load_done;
    logic [4:0]  feat_bram_addrb;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [1:0]  layer_idx;
    logic        reload_req;
    logic        busy;
    logic        done;
    logic        err;

    int          vec = 0;
    int          bad = 0;
    int          reload_cnt = 0;
    logic [7:0]  salt = 8'h11;
    logic [31:0] cap_data [16];
    logic        cap_last [16];

    always #5 clk = ~clk;

    gat_layer_scheduler #(
        .NUM_LAYERS (2),
        .FEAT_DEPTH (FD),
        .FEAT_WIDTH (32),
        .FEAT_ADDR_W(3),
        .RD_LAT     (2),
        .FIFO_DEPTH (4),
        .WDT_CYCLES (32'd100)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .h_data_load_done_in       (hl),
        .h_node_info_load_done_in  (nl),
        .wgt_load_done_in          (wl),
        .gat_ready                 (gat_ready),
        .feat_bram_dout            (feat_bram_dout),
        .out_ready                 (out_ready),
        .gat_layer                 (gat_layer),
        .h_data_bram_load_done     (h_data_bram_load_done),
        .h_node_info_bram_load_done(h_node_info_bram_load_done),
        .wgt_bram_load_done        (wgt_bram_load_done),
        .feat_bram_addrb           (feat_bram_addrb),
        .out_valid                 (out_valid),
        .out_data                  (out_data),
        .out_last                  (out_last),
        .layer_idx                 (layer_idx),
        .reload_req                (reload_req),
        .busy                      (busy),
        .done                      (done),
        .err                       (err)
    );

    function automatic logic [31:0] exp_word(input logic [7:0] s, input int i);
        return {s, 8'hC0, 16'(i * 273)};
    endfunction

    // Feature BRAM: one register stage, word content tagged by the current salt.
    always @(posedge clk) feat_bram_dout <= exp_word(salt, int'(feat_bram_addrb >> 2));

    always @(negedge clk) if (reload_req) reload_cnt++;

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go_run();
        hl = 1'b1; nl = 1'b1; wl = 1'b1;
        @(negedge clk);
        hl = 1'b0; nl = 1'b0; wl = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Records handshaken words; mode 1 toggles ready, then stalls 10 cycles.
    task automatic capture(input int mode, input int budget,
                           output int n, output int used, output int stab);
        logic [31:0] pd;
        logic        pl;
        logic        pstall;
        logic        got_last;
        n = 0; used = 0; stab = 0;
        pd = '0; pl = 1'b0; pstall = 1'b0; got_last = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cap_data[i] = '0;
            cap_last[i] = 1'b0;
        end
        for (int c = 0; c < budget && !got_last; c++) begin
            if (mode == 0 || c >= 18) out_ready = 1'b1;
            else if (c < 8)           out_ready = (c % 2 == 0);
            else                      out_ready = 1'b0;
            if (pstall && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl))
                stab++;
            if (out_valid && out_ready) begin
                if (n < 16) begin
                    cap_data[n] = out_data;
                    cap_last[n] = out_last;
                end
                n++;
                used = c + 1;
                if (out_last) got_last = 1'b1;
            end
            pstall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hl = 1'b0; nl = 1'b0; wl = 1'b0;
        gat_ready = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({out_valid, out_last, busy, done, err, reload_req, gat_layer} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {out_valid, out_last, busy, done, err, reload_req, gat_layer});
        end
        vec++;
        if (out_data !== 32'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", out_data);
        end
        vec++;
        if (layer_idx !== 2'd0 || feat_bram_addrb !== 5'd0) begin
            bad++;
            $display("FAIL reset_idx_addr: got %0d/%0d want 0/0", layer_idx, feat_bram_addrb);
        end
        vec++;
        if ({h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done} !== 3'b0) begin
            bad++; $display("FAIL reset_load_done: got nonzero want 000");
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL idle_no_start: busy %b want 0", busy);
        end
    endtask

    task automatic test_two_layer();
        int c, n, used, stab;
        salt = 8'h11; reload_cnt = 0; out_ready = 1'b1;
        pulse_start();
        vec++;
        if (busy !== 1'b1 || layer_idx !== 2'd0 || gat_layer !== 1'b0) begin
            bad++;
            $display("FAIL start_load: busy %b idx %0d gl %b want 1 0 0", busy, layer_idx, gat_layer);
        end
        go_run();
        vec++;
        if ({h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done} !== 3'b111) begin
            bad++; $display("FAIL run_load_done: got %b want 111",
                {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done});
        end
        gat_ready = 1'b1;
        wait_valid(20, c);
        vec++;
        if (c !== 5) begin
            bad++; $display("FAIL first_valid_latency: got %0d want 5", c);
        end
        capture(0, 40, n, used, stab);
        vec++;
        if (n !== FD || used !== FD) begin
            bad++; $display("FAIL l0_count_rate: got %0d words in %0d cycles want 8 in 8", n, used);
        end
        for (int i = 0; i < FD; i++) begin
            vec++;
            if (cap_data[i] !== exp_word(8'h11, i) || cap_last[i] !== (i == FD - 1)) begin
                bad++;
                $display("FAIL l0_word%0d: got %h last %b want %h last %b",
                         i, cap_data[i], cap_last[i], exp_word(8'h11, i), (i == FD - 1));
            end
        end
        vec++;
        if (reload_req !== 1'b1 || layer_idx !== 2'd1 || feat_bram_addrb !== 5'd28) begin
            bad++;
            $display("FAIL next_state: rr %b idx %0d addr %0d want 1 1 28",
                     reload_req, layer_idx, feat_bram_addrb);
        end
        gat_ready = 1'b0;
        @(negedge clk);
        vec++;
        if (reload_req !== 1'b0 || gat_layer !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL layer1_load: rr %b gl %b busy %b want 0 1 1", reload_req, gat_layer, busy);
        end
        salt = 8'h5A;
        go_run();
        gat_ready = 1'b1;
        wait_valid(20, c);
        capture(0, 40, n, used, stab);
        vec++;
        if (n !== FD) begin
            bad++; $display("FAIL l1_count: got %0d want 8", n);
        end
        for (int i = 0; i < FD; i++) begin
            vec++;
            if (cap_data[i] !== exp_word(8'h5A, i) || cap_last[i] !== (i == FD - 1)) begin
                bad++;
                $display("FAIL l1_word%0d: got %h last %b want %h", i, cap_data[i], cap_last[i],
                         exp_word(8'h5A, i));
            end
        end
        vec++;
        if (done !== 1'b1 || busy !== 1'b0 || reload_cnt !== 1 || gat_layer !== 1'b1) begin
            bad++;
            $display("FAIL run_done: done %b busy %b reloads %0d gl %b want 1 0 1 1",
                     done, busy, reload_cnt, gat_layer);
        end
    endtask

    task automatic test_backpressure();
        int c, n, used, stab;
        salt = 8'h2B; gat_ready = 1'b0; out_ready = 1'b0;
        pulse_start();
        go_run();
        gat_ready = 1'b1;
        wait_valid(20, c);
        capture(1, 80, n, used, stab);
        vec++;
        if (n !== FD || stab !== 0) begin
            bad++; $display("FAIL bp_count_stable: got %0d words %0d unstable want 8 0", n, stab);
        end
        for (int i = 0; i < FD; i++) begin
            vec++;
            if (cap_data[i] !== exp_word(8'h2B, i) || cap_last[i] !== (i == FD - 1)) begin
                bad++;
                $display("FAIL bp_word%0d: got %h last %b want %h", i, cap_data[i], cap_last[i],
                         exp_word(8'h2B, i));
            end
        end
    endtask

    task automatic test_ready_high_at_entry();
        int c, n, used, stab;
        @(negedge clk);
        salt = 8'h3C;
        go_run();
        repeat (10) @(negedge clk);
        vec++;
        if (h_data_bram_load_done !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL held_high_in_run: ld %b valid %b want 1 0", h_data_bram_load_done, out_valid);
        end
        gat_ready = 1'b0;
        repeat (2) @(negedge clk);
        gat_ready = 1'b1;
        wait_valid(20, c);
        vec++;
        if (c !== 5 || h_data_bram_load_done !== 1'b0) begin
            bad++; $display("FAIL rise_to_readout: latency %0d ld %b want 5 0", c, h_data_bram_load_done);
        end
        capture(0, 40, n, used, stab);
        vec++;
        if (n !== FD || cap_data[0] !== exp_word(8'h3C, 0) || cap_data[7] !== exp_word(8'h3C, 7)) begin
            bad++; $display("FAIL rh_stream: got %0d words first %h want 8 %h", n, cap_data[0],
                            exp_word(8'h3C, 0));
        end
        vec++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL rh_done: got %b want 1", done);
        end
    endtask

    task automatic test_start_busy();
        int first_run;
        salt = 8'h77; gat_ready = 1'b0; out_ready = 1'b1;
        pulse_start();
        vec++;
        if (done !== 1'b0 || busy !== 1'b1 || layer_idx !== 2'd0) begin
            bad++; $display("FAIL restart: done %b busy %b idx %0d want 0 1 0", done, busy, layer_idx);
        end
        pulse_start();
        vec++;
        if (busy !== 1'b1 || layer_idx !== 2'd0 || h_data_bram_load_done !== 1'b0) begin
            bad++; $display("FAIL start_in_load: busy %b idx %0d ld %b want 1 0 0",
                            busy, layer_idx, h_data_bram_load_done);
        end
        first_run = -1;
        for (int c = 0; c < 20; c++) begin
            wl = (c == 2);
            hl = (c == 8);
            nl = (c == 17);
            @(negedge clk);
            if (h_data_bram_load_done === 1'b1 && first_run < 0) first_run = c;
        end
        wl = 1'b0; hl = 1'b0; nl = 1'b0;
        vec++;
        if (first_run !== 18) begin
            bad++; $display("FAIL flags_to_run: run seen at %0d want 18", first_run);
        end
        vec++;
        if (h_node_info_bram_load_done !== 1'b1 || wgt_bram_load_done !== 1'b1) begin
            bad++; $display("FAIL other_load_done: got %b%b want 11",
                            h_node_info_bram_load_done, wgt_bram_load_done);
        end
        pulse_start();
        vec++;
        if (layer_idx !== 2'd0 || h_data_bram_load_done !== 1'b1) begin
            bad++; $display("FAIL start_in_run: idx %0d ld %b want 0 1", layer_idx, h_data_bram_load_done);
        end
    endtask

    task automatic test_reset_mid_readout();
        int c, n, used, stab;
        gat_ready = 1'b1; out_ready = 1'b1;
        wait_valid(20, c);
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (out_data !== exp_word(8'h77, i)) begin
                bad++; $display("FAIL pre_rst_word%0d: got %h want %h", i, out_data, exp_word(8'h77, i));
            end
            @(negedge clk);
        end
        vec++;
        if (out_data !== exp_word(8'h77, 3)) begin
            bad++; $display("FAIL word3: got %h want %h", out_data, exp_word(8'h77, 3));
        end
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        vec++;
        if ({out_valid, out_last, busy, done, err, reload_req, gat_layer} !== 7'b0 ||
            out_data !== 32'h0 || layer_idx !== 2'd0 || feat_bram_addrb !== 5'd0) begin
            bad++;
            $display("FAIL mid_reset: flags %b data %h idx %0d addr %0d want all 0",
                     {out_valid, out_last, busy, done, err, reload_req, gat_layer},
                     out_data, layer_idx, feat_bram_addrb);
        end
        rst = 1'b0; gat_ready = 1'b0; salt = 8'h99; out_ready = 1'b1;
        pulse_start();
        go_run();
        gat_ready = 1'b1;
        wait_valid(20, c);
        capture(0, 40, n, used, stab);
        vec++;
        if (n !== FD) begin
            bad++; $display("FAIL fresh_count: got %0d want 8", n);
        end
        for (int i = 0; i < FD; i++) begin
            vec++;
            if (cap_data[i] !== exp_word(8'h99, i) || cap_last[i] !== (i == FD - 1)) begin
                bad++;
                $display("FAIL fresh_word%0d: got %h want %h", i, cap_data[i], exp_word(8'h99, i));
            end
        end
    endtask

`ifdef GAT_SCHED_WDT_EN
    task automatic test_watchdog();
        int c;
        repeat (2) @(negedge clk);
        gat_ready = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();
        pulse_start();
        go_run();
        c = 0;
        while (busy && c < 300) begin
            @(negedge clk);
            c++;
        end
        vec++;
        if (c !== 100 || err !== 1'b1 || h_data_bram_load_done !== 1'b0) begin
            bad++; $display("FAIL wdt_trip: cycles %0d err %b ld %b want 100 1 0",
                            c, err, h_data_bram_load_done);
        end
        pulse_start();
        vec++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL wdt_clear: err %b busy %b want 0 1", err, busy);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_two_layer();
        test_backpressure();
        test_ready_high_at_entry();
        test_start_busy();
        test_reset_mid_readout();
`ifdef GAT_SCHED_WDT_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/gat_layer_scheduler.md
Name: gat_layer_scheduler

Overview:
- Sequences multi-layer GAT inference around the GAT top-level wrapper.
- Collects host BRAM-load completion flags and drives the layer select and load-done inputs of the accelerator.
- Waits for accelerator completion, then streams the new-feature BRAM out through a backpressured valid/ready port.
- Requests a host reload between layers. Sits between the register-bank/DMA side and the accelerator.

Parameters:
- NUM_LAYERS, 2, number of GAT layers run per start.
- FEAT_DEPTH, 43328, new-feature words per layer (NUM_SUBGRAPHS*NUM_FEATURE_OUT).
- FEAT_WIDTH, 32, new-feature word width.
- FEAT_ADDR_W, $clog2(FEAT_DEPTH), word-address width.
- RD_LAT, 2, feature BRAM read latency in cycles (>=1).
- FIFO_DEPTH, 4, output FIFO entries (>=RD_LAT+1).
- WDT_CYCLES, 2^24, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begin run
- h_data_load_done_in  in  1  host pulse/level: H data loaded
- h_node_info_load_done_in  in  1  host: node info loaded
- wgt_load_done_in  in  1  host: weights loaded
- gat_ready  in  1  accelerator completion level
- feat_bram_dout  in  FEAT_WIDTH  feature BRAM read data
- out_ready  in  1  downstream ready
- gat_layer  out  1  layer select to accelerator (layer_idx[0])
- h_data_bram_load_done  out  1  to accelerator
- h_node_info_bram_load_done  out  1  to accelerator
- wgt_bram_load_done  out  1  to accelerator
- feat_bram_addrb  out  FEAT_ADDR_W+2  byte address, word index<<2
- out_valid  out  1  stream valid
- out_data  out  FEAT_WIDTH  feature word
- out_last  out  1  final word of layer
- layer_idx  out  $clog2(NUM_LAYERS)+1  current layer
- reload_req  out  1  one-cycle pulse, host must reload BRAMs
- busy  out  1  state not IDLE/DONE
- done  out  1  sticky all-layers-complete
- err  out  1  watchdog error (0 when feature absent)

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, sticky flags cleared, FIFO emptied, in-flight reads discarded (their valid pipeline is cleared). Mid-operation reset takes effect on the next edge.
- Sticky flags: each *_load_done_in sets its own flag. Flags clear on entry to LOAD.
- IDLE / DONE:
  - start -> LOAD, layer_idx=0, done cleared.
  - start ignored in all other states.
- LOAD: when all three flags are set -> RUN.
- RUN:
  - Three load_done outputs are high exactly while in RUN.
  - gat_layer = layer_idx[0], held stable from LOAD through READOUT.
  - gat_ready is registered. Exit only on a 0->1 edge seen in RUN; a level already high at RUN entry is ignored until it drops and rises.
  - Edge -> READOUT.
- READOUT:
  - Word index runs 0..FEAT_DEPTH-1. A read issues when index<FEAT_DEPTH and fifo_count+inflight<FIFO_DEPTH.
  - Read data is captured RD_LAT cycles after the address and written to the FIFO.
  - First out_valid comes RD_LAT+1 cycles after READOUT entry.
  - With out_ready held high, throughput is 1 word/cycle.
  - out_last is high with word FEAT_DEPTH-1.
  - When out_valid&out_ready&out_last: go to DONE if layer_idx==NUM_LAYERS-1, else NEXT.
  - Stream protocol: out_data/out_last held stable while out_valid&!out_ready; no word dropped or duplicated.
- NEXT: layer_idx+1, reload_req pulses for 1 cycle -> LOAD.
- DONE: done=1 until start or rst.
- Simultaneous FIFO push and pop: count unchanged.
- feat_bram_addrb holds its last value when not issuing.

Optional Feature:
- Macro: GAT_SCHED_WDT_EN.
- Defined:
  - 32-bit counter clears on RUN entry and increments each RUN cycle.
  - When it reaches WDT_CYCLES: state -> IDLE, err=1 (sticky until start or rst), load_done outputs drop.
- Undefined: no counter; err tied 0; RUN waits indefinitely.

Test Plan:
- Full two-layer run (FEAT_DEPTH=8, RD_LAT=2):
  - Stimulus: start; three load pulses; gat_ready rise; reload; repeat.
  - Response: 8 words per layer, data matching BRAM model at addrb 0,4,...,28. out_last on the 8th word. One reload_req pulse between layers. gat_layer 0 then 1. done=1.
- Backpressure:
  - Stimulus: out_ready toggled 1010..., then held low 10 cycles.
  - Response: no loss or duplication, out_data stable while stalled, inflight+count never exceeds 4.
- gat_ready already high at RUN entry:
  - Stimulus: gat_ready high at entry, no edge.
  - Response: stays in RUN. After 0 then 1, enters READOUT.
- Start while busy: ignored, layer_idx unchanged. Load flags arriving in any order over 20 cycles -> RUN one cycle after the last flag.
- Reset mid-readout: rst at word 3 -> all outputs 0, busy=0. A fresh run starts from word 0.
- With GAT_SCHED_WDT_EN defined (WDT_CYCLES=100): no gat_ready -> err=1 and IDLE after 100 RUN cycles. Next start clears err.
